mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single memory_interface (32-bit load/store front end to the 16-bit memory) between two requesters: the instruction-fetch port and the data load/store port.
- Selects a winner and latches its request, then issues one load/store strobe to memory_interface.
- Waits for completion, then returns data or a store-done pulse to the owning requester.
- Sits between the CPU core and memory_interface.

Parameters:
- ADDR_WIDTH, 12, byte address width; matches memory_interface address.
- STARVE_LIMIT, 4, consecutive data grants allowed while if_req is pending before fetch is forced to win.
- TIMEOUT, 16, WAIT-state cycles before the access is aborted with err.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-low
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  ADDR_WIDTH  fetch address
- if_ack  out  1  one-cycle grant pulse
- if_rvalid  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  32  fetched halfword, zero-extended
- d_req  in  1  data request; held until d_ack
- d_load  in  1  1 = load, 0 = store
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  32  store data
- d_signed  in  1  sign-extend on load
- d_word_type  in  2  00 BYTE, 01 HALFWORD, 10 WORD
- d_ack  out  1  one-cycle grant pulse
- d_done  out  1  one-cycle pulse, load data valid or store complete
- d_rdata  out  32  load result
- err  out  1  pulses with the rvalid/done of a timed-out access
- mi_address  out  ADDR_WIDTH  to memory_interface.address
- mi_data_in  out  32  to memory_interface.data_in
- mi_load  out  1  to memory_interface.load
- mi_store  out  1  to memory_interface.store
- mi_is_signed  out  1  to memory_interface.is_signed
- mi_word_type  out  2  to memory_interface.word_type
- mi_data_out  in  32  from memory_interface.data_out
- mi_output_valid  in  1  load complete
- mi_write_ready  in  1  store complete
- mi_busy  in  1  interface occupied

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. All state is registered.
- Reset (reset=0, asynchronous): state IDLE; all outputs 0; latched fields, starvation counter and timeout counter cleared.
- A reset during ISSUE, WAIT or RESP aborts the access. No ack, done or rvalid is emitted afterwards.

IDLE:
- Arbitrate only when mi_busy=0 and (if_req or d_req).
- Only one requester: it wins.
- Both requesting: data wins while starve_cnt < STARVE_LIMIT; otherwise fetch wins.
- On the clock edge: latch winner's fields and owner, go to ISSUE.
- A fetch is latched as load, HALFWORD, unsigned.

Starvation counter (starve_cnt):
- Increments on a data grant while if_req=1, saturating at STARVE_LIMIT.
- Clears on a fetch grant, or on a data grant while if_req=0.

ISSUE (exactly 1 cycle):
- Owner's ack=1.
- mi_load or mi_store=1, with latched address, data, signed and word_type on mi_*.
- Go to WAIT.
- mi_address, mi_data_in, mi_is_signed and mi_word_type hold their latched values through WAIT; mi_load/mi_store are 0 outside ISSUE.

WAIT:
- Load completes on mi_output_valid=1; capture mi_data_out into the response register.
- Store completes on mi_write_ready=1.
- On completion, go to RESP.
- The timeout counter increments each WAIT cycle. Reaching TIMEOUT goes to RESP with err pending and response data 0.
- Completion and timeout in the same cycle: completion wins, err=0.

RESP (exactly 1 cycle):
- Owner's rvalid/done=1, with rdata set to the response register (0 for stores).
- err=1 if timed out.
- Go to IDLE; the counter clears.

Timing and requester rules:
- Minimum turnaround is 4 cycles (IDLE→ISSUE→WAIT→RESP). A new grant can occur in the cycle after RESP.
- Requests arriving during a busy access stay pending; the requester holds req.
- Requester deasserts req in the cycle after ack. A req still high after RESP counts as a new request.
- rdata outputs retain their value until the next response of the same port.

Decomposition:
- Package mem_arb_pkg holds:
  - localparams WORD=2'b10, HALFWORD=2'b01, BYTE=2'b00;
  - enum arb_state_t {IDLE, ISSUE, WAIT, RESP};
  - enum owner_t {OWN_IF, OWN_D}.
- Sub-module mem_arb_priority holds the combinational winner select plus the registered starvation counter. Inputs: clk, reset, if_req, d_req, grant strobe. Output: winner.

Test Plan:
- d_req only, store WORD 0xdeadbeef at 0xeed, write_ready 2 cycles after strobe → d_ack at cycle +1, mi_store single pulse, d_done 1 cycle after write_ready, err=0.
- d_req only, load HALFWORD signed from 0xeee, mi_data_out=0xffffbeef with output_valid → d_done pulse, d_rdata=0xffffbeef; if_rvalid stays 0.
- if_req and d_req both held continuously → grant order D,D,D,D,IF,D,D,D,D,IF; fetch mi_word_type=01, mi_is_signed=0.
- Load with mi_output_valid never asserted → after 16 WAIT cycles, d_done=1, err=1, d_rdata=0; the next request proceeds normally.
- mi_busy=1 with if_req=1 → no if_ack until mi_busy falls; if_ack is then seen in the following cycle.
- reset asserted in WAIT → all outputs 0 immediately; no if_rvalid/d_done after release; a held request is re-granted from IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the memory port arbiter.
//               Holds the memory_interface word_type codes, the arbiter
//               state enumeration and the access owner enumeration.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package mem_arb_pkg;

    // memory_interface word_type encodings
    localparam logic [1:0] BYTE     = 2'b00;
    localparam logic [1:0] HALFWORD = 2'b01;
    localparam logic [1:0] WORD     = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

endpackage

`default_nettype wire

// File: rtl/mem_arb_priority.sv
// ============================================================================
// Module      : mem_arb_priority
// Description : Winner select between fetch and data requesters with a
//               starvation counter that forces fetch to win after
//               STARVE_LIMIT consecutive data grants taken while fetch waited.
// Ports       : clk, reset (async, active-low)
//               if_req, d_req  - pending requests
//               grant          - strobe: the current winner is being granted
//               winner         - combinational winner for this cycle
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_arb_priority
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   if_req,
    input  logic   d_req,
    input  logic   grant,
    output owner_t winner
);

    localparam int                 c_CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    logic [c_CNT_W-1:0] r_starve_cnt;

    // Data is the default; fetch wins when alone or when data has
    // monopolised the port for STARVE_LIMIT grants.
    always_comb begin
        winner = OWN_D;
        if (if_req && !d_req) begin
            winner = OWN_IF;
        end else if (if_req && d_req && (r_starve_cnt >= c_LIMIT)) begin
            winner = OWN_IF;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_starve_cnt <= '0;
        end else if (grant) begin
            if ((winner == OWN_D) && if_req) begin
                if (r_starve_cnt < c_LIMIT) begin
                    r_starve_cnt <= r_starve_cnt + 1'b1;
                end
            end else begin
                r_starve_cnt <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory_interface between the instruction-fetch
//               port and the data load/store port. Latches the winning
//               request, issues a single load/store strobe, waits for
//               completion (or times out) and returns the response to the
//               owning port.
// Ports       : clk, reset (async, active-low)
//               if_*  - fetch requester (req/addr in, ack/rvalid/rdata out)
//               d_*   - data requester (req/load/addr/wdata/signed/word_type
//                       in, ack/done/rdata out)
//               err   - flags a timed-out response
//               mi_*  - memory_interface strobes, fields and status
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 12,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    // fetch port
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_ack,
    output logic                  if_rvalid,
    output logic [31:0]           if_rdata,
    // data port
    input  logic                  d_req,
    input  logic                  d_load,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [31:0]           d_wdata,
    input  logic                  d_signed,
    input  logic [1:0]            d_word_type,
    output logic                  d_ack,
    output logic                  d_done,
    output logic [31:0]           d_rdata,
    output logic                  err,
    // memory_interface
    output logic [ADDR_WIDTH-1:0] mi_address,
    output logic [31:0]           mi_data_in,
    output logic                  mi_load,
    output logic                  mi_store,
    output logic                  mi_is_signed,
    output logic [1:0]            mi_word_type,
    input  logic [31:0]           mi_data_out,
    input  logic                  mi_output_valid,
    input  logic                  mi_write_ready,
    input  logic                  mi_busy
);

    localparam logic [1:0] c_ST_IDLE  = IDLE;
    localparam logic [1:0] c_ST_ISSUE = ISSUE;
    localparam logic [1:0] c_ST_WAIT  = WAIT;
    localparam logic [1:0] c_ST_RESP  = RESP;

    localparam int                c_TO_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT - 1);

    logic [1:0]            r_state;
    owner_t                r_owner;
    logic                  r_load;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  r_signed;
    logic [1:0]            r_word_type;
    logic                  r_err;
    logic [c_TO_W-1:0]     r_tcnt;
    logic [31:0]           r_if_rdata;
    logic [31:0]           r_d_rdata;

    owner_t                w_winner;
    logic                  w_grant;
    logic                  w_complete;
    logic [31:0]           w_resp_data;

    assign w_grant     = (r_state == c_ST_IDLE) && !mi_busy && (if_req || d_req);
    assign w_complete  = r_load ? mi_output_valid : mi_write_ready;
    assign w_resp_data = r_load ? mi_data_out : 32'd0;

    mem_arb_priority #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_priority (
        .clk    (clk),
        .reset  (reset),
        .if_req (if_req),
        .d_req  (d_req),
        .grant  (w_grant),
        .winner (w_winner)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_ST_IDLE;
            r_owner     <= OWN_IF;
            r_load      <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_signed    <= 1'b0;
            r_word_type <= 2'b00;
            r_err       <= 1'b0;
            r_tcnt      <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_tcnt <= '0;
                    if (w_grant) begin
                        r_owner <= w_winner;
                        r_err   <= 1'b0;
                        r_state <= c_ST_ISSUE;
                        if (w_winner == OWN_IF) begin
                            // fetches are always unsigned halfword loads
                            r_load      <= 1'b1;
                            r_addr      <= if_addr;
                            r_wdata     <= '0;
                            r_signed    <= 1'b0;
                            r_word_type <= HALFWORD;
                        end else begin
                            r_load      <= d_load;
                            r_addr      <= d_addr;
                            r_wdata     <= d_wdata;
                            r_signed    <= d_signed;
                            r_word_type <= d_word_type;
                        end
                    end
                end
                c_ST_ISSUE: begin
                    r_state <= c_ST_WAIT;
                end
                c_ST_WAIT: begin
                    // completion is checked first so a late completion on the
                    // last allowed cycle still counts as success
                    if (w_complete) begin
                        if (r_owner == OWN_IF) begin
                            r_if_rdata <= w_resp_data;
                        end else begin
                            r_d_rdata <= w_resp_data;
                        end
                        r_err   <= 1'b0;
                        r_state <= c_ST_RESP;
                    end else if (r_tcnt == c_TO_LAST) begin
                        if (r_owner == OWN_IF) begin
                            r_if_rdata <= '0;
                        end else begin
                            r_d_rdata <= '0;
                        end
                        r_err   <= 1'b1;
                        r_state <= c_ST_RESP;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                c_ST_RESP: begin
                    r_tcnt  <= '0;
                    r_err   <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign if_ack       = (r_state == c_ST_ISSUE) && (r_owner == OWN_IF);
    assign d_ack        = (r_state == c_ST_ISSUE) && (r_owner == OWN_D);
    assign if_rvalid    = (r_state == c_ST_RESP) && (r_owner == OWN_IF);
    assign d_done       = (r_state == c_ST_RESP) && (r_owner == OWN_D);
    assign err          = (r_state == c_ST_RESP) && r_err;
    assign if_rdata     = r_if_rdata;
    assign d_rdata      = r_d_rdata;

    assign mi_load      = (r_state == c_ST_ISSUE) && r_load;
    assign mi_store     = (r_state == c_ST_ISSUE) && !r_load;
    assign mi_address   = r_addr;
    assign mi_data_in   = r_wdata;
    assign mi_is_signed = r_signed;
    assign mi_word_type = r_word_type;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. Directed vector
//               table, hand-written multi-cycle sequences (starvation order,
//               busy hold-off, reset mid-access) and a randomized phase
//               checked against a cycle-scheduled reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int c_AW      = 12;
    localparam int c_STARVE  = 4;
    localparam int c_TIMEOUT = 16;
    localparam int c_NR      = 1500;
    localparam int c_TAIL    = 80;
    localparam int c_ASZ     = c_NR + c_TAIL + 40;

    logic            clk, reset;
    logic            if_req, if_ack, if_rvalid;
    logic [c_AW-1:0] if_addr;
    logic [31:0]     if_rdata;
    logic            d_req, d_load, d_signed, d_ack, d_done;
    logic [c_AW-1:0] d_addr;
    logic [31:0]     d_wdata, d_rdata;
    logic [1:0]      d_word_type;
    logic            err;
    logic [c_AW-1:0] mi_address;
    logic [31:0]     mi_data_in, mi_data_out;
    logic            mi_load, mi_store, mi_is_signed;
    logic [1:0]      mi_word_type;
    logic            mi_output_valid, mi_write_ready, mi_busy;

    mem_port_arbiter #(
        .ADDR_WIDTH   (c_AW),
        .STARVE_LIMIT (c_STARVE),
        .TIMEOUT      (c_TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .if_req          (if_req),
        .if_addr         (if_addr),
        .if_ack          (if_ack),
        .if_rvalid       (if_rvalid),
        .if_rdata        (if_rdata),
        .d_req           (d_req),
        .d_load          (d_load),
        .d_addr          (d_addr),
        .d_wdata         (d_wdata),
        .d_signed        (d_signed),
        .d_word_type     (d_word_type),
        .d_ack           (d_ack),
        .d_done          (d_done),
        .d_rdata         (d_rdata),
        .err             (err),
        .mi_address      (mi_address),
        .mi_data_in      (mi_data_in),
        .mi_load         (mi_load),
        .mi_store        (mi_store),
        .mi_is_signed    (mi_is_signed),
        .mi_word_type    (mi_word_type),
        .mi_data_out     (mi_data_out),
        .mi_output_valid (mi_output_valid),
        .mi_write_ready  (mi_write_ready),
        .mi_busy         (mi_busy)
    );

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // memory contents seen by the responder
    function automatic logic [31:0] mem_word(input logic [c_AW-1:0] a);
        return {a ^ 12'h5a3, 8'hc3, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] pulses();
        return {25'd0, if_ack, d_ack, if_rvalid, d_done, err, mi_load, mi_store};
    endfunction

    // ---------------- memory_interface responder ----------------
    // resp_lat = N: completion pulse N cycles after the strobe; 0 = never.
    int          resp_lat      = 1;
    bit          use_override  = 1'b0;
    logic [31:0] resp_override = 32'd0;
    int          rs_cnt;
    logic        rs_load;
    logic [31:0] rs_data;

    initial begin
        mi_output_valid = 1'b0;
        mi_write_ready  = 1'b0;
        mi_data_out     = 32'd0;
        rs_cnt          = 0;
        rs_load         = 1'b0;
        rs_data         = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            mi_output_valid = 1'b0;
            mi_write_ready  = 1'b0;
            mi_data_out     = $urandom;
            if (!reset) begin
                rs_cnt = 0;
            end else begin
                if (rs_cnt > 0) begin
                    rs_cnt--;
                    if (rs_cnt == 0) begin
                        if (rs_load) begin
                            mi_output_valid = 1'b1;
                            mi_data_out     = rs_data;
                        end else begin
                            mi_write_ready = 1'b1;
                        end
                    end
                end
                if (mi_load || mi_store) begin
                    rs_cnt  = resp_lat;
                    rs_load = mi_load;
                    rs_data = use_override ? resp_override : mem_word(mi_address);
                end
            end
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        bit          fetch;
        bit          load;
        logic [11:0] addr;
        logic [31:0] wdata;
        bit          sgn;
        logic [1:0]  wt;
        int          lat;
        logic [31:0] mdata;
        int          exp_wait;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vt[8];

    task automatic run_vec(input int idx, input vec_t v);
        int   waited;
        int   extra;
        bit   got;
        logic eff_load;
        eff_load      = v.fetch ? 1'b1 : v.load;
        use_override  = 1'b1;
        resp_override = v.mdata;
        resp_lat      = v.lat;
        check($sformatf("v%0d_idle", idx), pulses(), 32'd0);
        if (v.fetch) begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end else begin
            d_req       = 1'b1;
            d_load      = v.load;
            d_addr      = v.addr;
            d_wdata     = v.wdata;
            d_signed    = v.sgn;
            d_word_type = v.wt;
        end
        tick();
        check($sformatf("v%0d_ack", idx), {30'd0, if_ack, d_ack}, v.fetch ? 32'd2 : 32'd1);
        check($sformatf("v%0d_strobe", idx), {30'd0, mi_load, mi_store}, eff_load ? 32'd2 : 32'd1);
        check($sformatf("v%0d_addr", idx), 32'(mi_address), 32'(v.addr));
        check($sformatf("v%0d_wtype", idx), 32'(mi_word_type), v.fetch ? 32'(HALFWORD) : 32'(v.wt));
        check($sformatf("v%0d_signed", idx), 32'(mi_is_signed), v.fetch ? 32'd0 : 32'(v.sgn));
        if (!eff_load) check($sformatf("v%0d_wdata", idx), mi_data_in, v.wdata);
        if_req = 1'b0;
        d_req  = 1'b0;
        waited = 0;
        extra  = 0;
        got    = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            if (mi_load || mi_store || if_ack || d_ack) extra++;
            if (if_rvalid || d_done) got = 1'b1;
            else waited++;
        end
        check($sformatf("v%0d_resp_seen", idx), 32'(got), 32'd1);
        check($sformatf("v%0d_wait_cycles", idx), waited, v.exp_wait);
        check($sformatf("v%0d_no_extra_strobe", idx), extra, 32'd0);
        check($sformatf("v%0d_resp_port", idx), {30'd0, if_rvalid, d_done}, v.fetch ? 32'd2 : 32'd1);
        check($sformatf("v%0d_err", idx), 32'(err), 32'(v.exp_err));
        check($sformatf("v%0d_rdata", idx), v.fetch ? if_rdata : d_rdata, v.exp_rdata);
        check($sformatf("v%0d_addr_hold", idx), 32'(mi_address), 32'(v.addr));
        tick();
        check($sformatf("v%0d_after", idx), pulses(), 32'd0);
        check($sformatf("v%0d_rdata_hold", idx), v.fetch ? if_rdata : d_rdata, v.exp_rdata);
        use_override = 1'b0;
    endtask

    // ---------------- random-phase scoreboard (indexed by cycle) ----------------
    logic        e_ack_if [c_ASZ];
    logic        e_ack_d  [c_ASZ];
    logic        e_rv_if  [c_ASZ];
    logic        e_done_d [c_ASZ];
    logic        e_err    [c_ASZ];
    logic        e_ld     [c_ASZ];
    logic [11:0] e_addr   [c_ASZ];
    logic [1:0]  e_wt     [c_ASZ];
    logic        e_sg     [c_ASZ];
    logic [31:0] e_wd     [c_ASZ];
    logic [31:0] e_rdata  [c_ASZ];

    bit exp_if_order [10];

    initial begin
        int          got_n;
        int          free_from;
        int          sc;
        bit          if_pend, d_pend, win_if, to;
        int          lat, w, r;
        logic [11:0] a;

        reset = 1'b0;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_load = 1'b0; d_addr = '0; d_wdata = '0; d_signed = 1'b0; d_word_type = 2'b00;
        mi_busy = 1'b0;

        vt[0] = '{fetch:0, load:0, addr:12'heed, wdata:32'hdeadbeef, sgn:0, wt:WORD,     lat:2,  mdata:32'h0,        exp_wait:2,  exp_rdata:32'h0,        exp_err:0};
        vt[1] = '{fetch:0, load:1, addr:12'heee, wdata:32'h0,        sgn:1, wt:HALFWORD, lat:1,  mdata:32'hffffbeef, exp_wait:1,  exp_rdata:32'hffffbeef, exp_err:0};
        vt[2] = '{fetch:1, load:1, addr:12'h100, wdata:32'h0,        sgn:0, wt:WORD,     lat:3,  mdata:32'h00001234, exp_wait:3,  exp_rdata:32'h00001234, exp_err:0};
        vt[3] = '{fetch:0, load:1, addr:12'h004, wdata:32'h0,        sgn:0, wt:WORD,     lat:0,  mdata:32'h77777777, exp_wait:16, exp_rdata:32'h0,        exp_err:1};
        vt[4] = '{fetch:0, load:1, addr:12'h005, wdata:32'h0,        sgn:0, wt:BYTE,     lat:4,  mdata:32'h000000a5, exp_wait:4,  exp_rdata:32'h000000a5, exp_err:0};
        vt[5] = '{fetch:0, load:1, addr:12'h008, wdata:32'h0,        sgn:1, wt:WORD,     lat:16, mdata:32'h12345678, exp_wait:16, exp_rdata:32'h12345678, exp_err:0};
        vt[6] = '{fetch:1, load:1, addr:12'h200, wdata:32'h0,        sgn:0, wt:WORD,     lat:17, mdata:32'h00005555, exp_wait:16, exp_rdata:32'h0,        exp_err:1};
        vt[7] = '{fetch:0, load:0, addr:12'h3ff, wdata:32'h000000ab, sgn:0, wt:BYTE,     lat:1,  mdata:32'h0,        exp_wait:1,  exp_rdata:32'h0,        exp_err:0};
        exp_if_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

        // ---- reset state ----
        tick();
        tick();
        check("rst_pulses", pulses(), 32'd0);
        check("rst_mi_fields", {mi_address, 1'b0, mi_is_signed, mi_word_type, 16'd0}, 32'd0);
        check("rst_rdata", if_rdata | d_rdata | mi_data_in, 32'd0);
        reset = 1'b1;
        tick();
        check("post_rst_idle", pulses(), 32'd0);

        // ---- table ----
        for (int i = 0; i < 8; i++) run_vec(i, vt[i]);

        // ---- starvation order with both ports held ----
        resp_lat = 1;
        if_req = 1'b1; if_addr = 12'h0c4;
        d_req = 1'b1; d_load = 1'b1; d_addr = 12'h0d8; d_word_type = WORD; d_signed = 1'b1;
        got_n = 0;
        for (int i = 0; i < 80 && got_n < 10; i++) begin
            tick();
            if (if_ack || d_ack) begin
                check($sformatf("order_%0d_is_fetch", got_n), 32'(if_ack), 32'(exp_if_order[got_n]));
                if (if_ack) begin
                    check($sformatf("order_%0d_fetch_wtype", got_n), 32'(mi_word_type), 32'(HALFWORD));
                    check($sformatf("order_%0d_fetch_signed", got_n), 32'(mi_is_signed), 32'd0);
                end
                got_n++;
            end
        end
        check("order_count", got_n, 10);
        if_req = 1'b0; d_req = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        // ---- mi_busy holds off arbitration ----
        mi_busy = 1'b1; if_req = 1'b1; if_addr = 12'h0a0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("busy_no_ack_%0d", i), 32'(if_ack), 32'd0);
        end
        mi_busy = 1'b0;
        tick();
        check("busy_release_ack", 32'(if_ack), 32'd1);
        if_req = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("busy_rdata", if_rdata, mem_word(12'h0a0));

        // ---- reset in WAIT ----
        resp_lat = 0;
        d_req = 1'b1; d_load = 1'b1; d_addr = 12'h0e4; d_word_type = WORD; d_signed = 1'b0;
        tick();
        check("rstw_ack", 32'(d_ack), 32'd1);
        tick(); tick(); tick();
        reset = 1'b0;
        #1;
        check("rstw_pulses", pulses(), 32'd0);
        check("rstw_mi_fields", {mi_address, 1'b0, mi_is_signed, mi_word_type, 16'd0}, 32'd0);
        check("rstw_rdata", if_rdata | d_rdata | mi_data_in, 32'd0);
        tick();
        check("rstw_hold", pulses(), 32'd0);
        resp_lat = 1;
        reset = 1'b1;
        tick();
        check("rstw_regrant", {29'd0, d_ack, d_done, if_rvalid}, 32'd4);
        d_req = 1'b0;
        tick();
        check("rstw_wait", pulses(), 32'd0);
        tick();
        check("rstw_done", {30'd0, d_done, err}, 32'd2);
        check("rstw_done_rdata", d_rdata, mem_word(12'h0e4));
        for (int i = 0; i < 3; i++) tick();

        // ---- randomized phase against the reference model ----
        for (int j = 0; j < c_ASZ; j++) begin
            e_ack_if[j] = 0; e_ack_d[j] = 0; e_rv_if[j] = 0; e_done_d[j] = 0; e_err[j] = 0;
            e_ld[j] = 0; e_addr[j] = '0; e_wt[j] = '0; e_sg[j] = 0; e_wd[j] = '0; e_rdata[j] = '0;
        end
        free_from = 0;
        sc = 0;
        if_pend = 0;
        d_pend = 0;
        for (int j = 0; j < c_NR + c_TAIL; j++) begin
            tick();
            check("rnd_if_ack", 32'(if_ack), 32'(e_ack_if[j]));
            check("rnd_d_ack", 32'(d_ack), 32'(e_ack_d[j]));
            check("rnd_if_rvalid", 32'(if_rvalid), 32'(e_rv_if[j]));
            check("rnd_d_done", 32'(d_done), 32'(e_done_d[j]));
            check("rnd_err", 32'(err), 32'(e_err[j]));
            check("rnd_strobe", {30'd0, mi_load, mi_store},
                  (e_ack_if[j] || e_ack_d[j]) ? (e_ld[j] ? 32'd2 : 32'd1) : 32'd0);
            if (e_ack_if[j] || e_ack_d[j]) begin
                check("rnd_mi_addr", 32'(mi_address), 32'(e_addr[j]));
                check("rnd_mi_wtype", 32'(mi_word_type), 32'(e_wt[j]));
                check("rnd_mi_signed", 32'(mi_is_signed), 32'(e_sg[j]));
                if (!e_ld[j]) check("rnd_mi_wdata", mi_data_in, e_wd[j]);
            end
            if (e_rv_if[j]) check("rnd_if_rdata", if_rdata, e_rdata[j]);
            if (e_done_d[j]) check("rnd_d_rdata", d_rdata, e_rdata[j]);

            // requesters: hold until ack, drop the cycle after
            if (e_ack_if[j]) if_pend = 0;
            if (e_ack_d[j]) d_pend = 0;
            if (j < c_NR && !if_pend && !e_ack_if[j] && ($urandom % 3 == 0)) begin
                if_pend = 1;
                if_addr = 12'($urandom);
            end
            if (j < c_NR && !d_pend && !e_ack_d[j] && ($urandom % 3 == 0)) begin
                d_pend      = 1;
                d_load      = 1'($urandom);
                d_addr      = 12'($urandom);
                d_wdata     = $urandom;
                d_signed    = 1'($urandom);
                d_word_type = 2'($urandom_range(0, 2));
            end
            if_req  = if_pend || e_ack_if[j];
            d_req   = d_pend || e_ack_d[j];
            mi_busy = (j < c_NR) && ($urandom % 6 == 0);

            // model: arbitrate when the port is free
            if (j >= free_from && !mi_busy && (if_req || d_req)) begin
                win_if = (if_req && d_req) ? (sc >= c_STARVE) : if_req;
                if (!win_if && if_req) sc = (sc < c_STARVE) ? sc + 1 : c_STARVE;
                else sc = 0;
                lat = ($urandom % 8 == 0) ? 0 : $urandom_range(1, 20);
                to  = (lat == 0) || (lat > c_TIMEOUT);
                w   = to ? c_TIMEOUT : lat;
                r   = j + 2 + w;
                free_from = r + 1;
                resp_lat  = lat;
                a = win_if ? if_addr : d_addr;
                e_ack_if[j+1] = win_if;
                e_ack_d[j+1]  = !win_if;
                e_ld[j+1]     = win_if ? 1'b1 : d_load;
                e_addr[j+1]   = a;
                e_wt[j+1]     = win_if ? HALFWORD : d_word_type;
                e_sg[j+1]     = win_if ? 1'b0 : d_signed;
                e_wd[j+1]     = d_wdata;
                e_rv_if[r]    = win_if;
                e_done_d[r]   = !win_if;
                e_err[r]      = to;
                e_rdata[r]    = (to || !e_ld[j+1]) ? 32'd0 : mem_word(a);
            end
        end
        check("rnd_drained", {30'd0, if_pend, d_pend}, 32'd0);
        check("rnd_idle_end", pulses(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
